// File: rtl/skolem_sweep_ctrl_if.sv
// Host/checker bundle for the Skolem sweep controller.
// slave = controller side, master = host plus Skolem unit/spec stub.
interface skolem_sweep_ctrl_if #(
  parameter int N_IN  = 6,
  parameter int N_OUT = 2
);
  logic             start;
  logic             abort;
  logic [N_IN-1:0]  x_out;
  logic [N_OUT-1:0] y_in;
  logic             spec_ok;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN:0]    fail_cnt;
  logic             first_fail_vld;
  logic [N_IN-1:0]  first_fail_x;
  logic [N_OUT-1:0] first_fail_y;

  modport slave (
    input  start, abort, y_in, spec_ok,
    output x_out, busy, done, pass, fail_cnt,
    output first_fail_vld, first_fail_x, first_fail_y
  );

  modport master (
    output start, abort, y_in, spec_ok,
    input  x_out, busy, done, pass, fail_cnt,
    input  first_fail_vld, first_fail_x, first_fail_y
  );
endinterface

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep of a Skolem unit over all 2^N_IN inputs,
// counting spec failures and capturing the lowest failing vector.
module skolem_sweep_ctrl #(
  parameter int N_IN     = 6,
  parameter int N_OUT    = 2,
  parameter int EVAL_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  skolem_sweep_ctrl_if.slave bus
);
  localparam int CW = (EVAL_LAT < 1) ? 1 : $clog2(EVAL_LAT + 1);
  localparam int FW = N_IN + 1;
  localparam logic [CW-1:0] LAT = CW'(EVAL_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE, SETTLE, SAMPLE, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  x_q, x_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic             ffv_q, ffv_d;
  logic [N_IN-1:0]  ffx_q, ffx_d;
  logic [N_OUT-1:0] ffy_q, ffy_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    ffv_d   = ffv_q;
    ffx_d   = ffx_q;
    ffy_d   = ffy_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          fcnt_d  = '0;
          ffv_d   = 1'b0;
          ffx_d   = '0;
          ffy_d   = '0;
          pass_d  = 1'b0;
          x_d     = '0;
          cnt_d   = LAT;
          state_d = (EVAL_LAT == 0) ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          if (!bus.spec_ok) begin
            fcnt_d = fcnt_q + FW'(1);
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffx_d = x_q;
              ffy_d = bus.y_in;
            end
          end
          if (&x_q) begin
            state_d = DONE;
          end else begin
            x_d     = x_q + N_IN'(1);
            cnt_d   = LAT;
            state_d = (EVAL_LAT == 0) ? SAMPLE : SETTLE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // pass lands together with done, so it sees the final sample
    if (state_d == DONE) pass_d = (fcnt_d == '0);
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      ffv_q   <= 1'b0;
      ffx_q   <= '0;
      ffy_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      ffv_q   <= ffv_d;
      ffx_q   <= ffx_d;
      ffy_q   <= ffy_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x_out          = x_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.fail_cnt       = fcnt_q;
  assign bus.first_fail_vld = ffv_q;
  assign bus.first_fail_x   = ffx_q;
  assign bus.first_fail_y   = ffy_q;
endmodule
